// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit:
// op codes, FSM encoding, reset polarity and zero constant.
package hilo_muldiv_pkg;

  localparam logic [2:0] HILO_OP_NOP   = 3'd0;
  localparam logic [2:0] HILO_OP_MULT  = 3'd1;
  localparam logic [2:0] HILO_OP_MULTU = 3'd2;
  localparam logic [2:0] HILO_OP_DIV   = 3'd3;
  localparam logic [2:0] HILO_OP_DIVU  = 3'd4;
  localparam logic [2:0] HILO_OP_MTHI  = 3'd5;
  localparam logic [2:0] HILO_OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MUL    = 2'd1,
    ST_DIV    = 2'd2,
    ST_DIVFIX = 2'd3
  } hilo_state_e;

  localparam logic RSTN_ENABLE = 1'b0;

  localparam logic [63:0] HILO_ZERO = 64'd0;

endpackage

// File: rtl/hilo_div_core.sv
// Iterative restoring divider, one quotient bit per cycle,
// with sign correction and divide-by-zero result override.
module hilo_div_core
  import hilo_muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              done_o,
  output logic [DATA_W-1:0] quo_o,
  output logic [DATA_W-1:0] rem_o
);

  localparam int CW = $clog2(DATA_W);

  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvd_q;
  logic [DATA_W-1:0] a_abs, b_abs;
  logic [DATA_W:0]   trial, diff;
  logic [CW-1:0]     cnt_q;
  logic              run_q, negq_q, negr_q, dz_q;
  logic              last;

  assign a_abs = (signed_i & a_i[DATA_W-1]) ? -a_i : a_i;
  assign b_abs = (signed_i & b_i[DATA_W-1]) ? -b_i : b_i;

  assign trial = {rem_q, quo_q[DATA_W-1]};
  assign diff  = trial - {1'b0, dvs_q};

  always_comb begin
    rem_d = trial[DATA_W-1:0];
    quo_d = {quo_q[DATA_W-2:0], 1'b0};
    if (!diff[DATA_W]) begin
      rem_d    = diff[DATA_W-1:0];
      quo_d[0] = 1'b1;
    end
  end

  assign last   = run_q & (cnt_q == CW'(DATA_W-1));
  assign done_o = last;

  always_ff @(posedge clk or negedge resetn) begin
    if (resetn == RSTN_ENABLE) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      dvd_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      dz_q   <= 1'b0;
    end else if (flush_i) begin
      run_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= '0;
      quo_q  <= a_abs;
      dvs_q  <= b_abs;
      dvd_q  <= a_i;
      cnt_q  <= '0;
      run_q  <= 1'b1;
      negq_q <= signed_i & (a_i[DATA_W-1] ^ b_i[DATA_W-1]);
      negr_q <= signed_i & a_i[DATA_W-1];
      dz_q   <= (b_i == '0);
    end else if (run_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + 1'b1;
      if (last) run_q <= 1'b0;
    end
  end

  // MIN/-1 needs no override: |MIN| / 1 with equal signs wraps to MIN, rem 0.
  assign quo_o = dz_q ? '1 : (negq_q ? -quo_q : quo_q);
  assign rem_o = dz_q ? dvd_q : (negr_q ? -rem_q : rem_q);

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with latency-counted multiplier,
// iterative divider, MT forwarding and flush abort.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              op_valid,
  input  logic [2:0]        op_code,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              op_ready,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  input  logic              r_en_hi,
  input  logic              r_en_lo,
  output logic [DATA_W-1:0] r_data_hi,
  output logic [DATA_W-1:0] r_data_lo,
  output logic              rd_stall
);

  localparam int CW = $clog2(MUL_LAT + 1);

  hilo_state_e state_q, state_d;

  logic [DATA_W-1:0]   hi_q, lo_q;
  logic [DATA_W-1:0]   ma_q, mb_q;
  logic                msgn_q;
  logic [CW-1:0]       mcnt_q;
  logic                done_q;
  logic [2*DATA_W-1:0] ma_x, mb_x, prod;
  logic [DATA_W-1:0]   quo, rem;
  logic acc, is_mul, is_div, is_mthi, is_mtlo;
  logic mul_last, div_last, wr_mul, wr_div;

  assign acc = op_valid & op_ready & ~flush;

  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    unique case (1'b1)
      (op_code == HILO_OP_MULT),
      (op_code == HILO_OP_MULTU): is_mul  = acc;
      (op_code == HILO_OP_DIV),
      (op_code == HILO_OP_DIVU):  is_div  = acc;
      (op_code == HILO_OP_MTHI):  is_mthi = acc;
      (op_code == HILO_OP_MTLO):  is_mtlo = acc;
      default: ;
    endcase
  end

  assign ma_x = {{DATA_W{msgn_q & ma_q[DATA_W-1]}}, ma_q};
  assign mb_x = {{DATA_W{msgn_q & mb_q[DATA_W-1]}}, mb_q};
  assign prod = ma_x * mb_x;

  assign mul_last = (state_q == ST_MUL) & (mcnt_q == CW'(MUL_LAT - 1));
  assign wr_mul   = mul_last & ~flush;
  assign wr_div   = (state_q == ST_DIVFIX) & ~flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (resetn == RSTN_ENABLE) begin
      ma_q   <= '0;
      mb_q   <= '0;
      msgn_q <= 1'b0;
      mcnt_q <= '0;
    end else if (is_mul) begin
      ma_q   <= op_a;
      mb_q   <= op_b;
      msgn_q <= (op_code == HILO_OP_MULT);
      mcnt_q <= '0;
    end else if (state_q == ST_MUL) begin
      mcnt_q <= mcnt_q + 1'b1;
    end
  end

  hilo_div_core #(.DATA_W(DATA_W)) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .start_i  (is_div),
    .flush_i  (flush),
    .signed_i (op_code == HILO_OP_DIV),
    .a_i      (op_a),
    .b_i      (op_b),
    .done_o   (div_last),
    .quo_o    (quo),
    .rem_o    (rem)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (resetn == RSTN_ENABLE) state_q <= ST_IDLE;
    else                       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (is_mul)      state_d = ST_MUL;
        else if (is_div) state_d = ST_DIV;
      end
      ST_MUL: begin
        if (flush | mul_last) state_d = ST_IDLE;
      end
      ST_DIV: begin
        if (flush)         state_d = ST_IDLE;
        else if (div_last) state_d = ST_DIVFIX;
      end
      ST_DIVFIX: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    op_ready  = ~busy;
    rd_stall  = busy & (r_en_hi | r_en_lo);
    r_data_hi = '0;
    r_data_lo = '0;
    if (r_en_hi) r_data_hi = is_mthi ? op_a : hi_q;
    if (r_en_lo) r_data_lo = is_mtlo ? op_a : lo_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (resetn == RSTN_ENABLE) begin
      hi_q   <= DATA_W'(HILO_ZERO);
      lo_q   <= DATA_W'(HILO_ZERO);
      done_q <= 1'b0;
    end else begin
      done_q <= wr_mul | wr_div;
      if (is_mthi) hi_q <= op_a;
      if (is_mtlo) lo_q <= op_a;
      if (wr_mul) begin
        hi_q <= prod[2*DATA_W-1:DATA_W];
        lo_q <= prod[DATA_W-1:0];
      end
      if (wr_div) begin
        hi_q <= rem;
        lo_q <= quo;
      end
    end
  end

  assign done = done_q;

endmodule
